// File: rtl/hazard_scoreboard_pkg.sv
// Purpose : shared constants for the D-stage Tuse/Tnew hazard scoreboard.
//           Default geometry plus the Tuse/Tnew encodings that decode
//           assigns to each MIPS instruction class.
// Ports   : none (package).
package hazard_scoreboard_pkg;

  localparam int AW_DEF     = 5;
  localparam int TW_DEF     = 3;
  localparam int NSTAGE_DEF = 3;
  localparam int NRD_DEF    = 2;
  localparam int CW_DEF     = 32;

  // Operand-unused marker for the default Tuse width (all ones).
  localparam logic [TW_DEF-1:0] TNONE_DEF = 3'b111;

  // Tuse: cycles from D until the operand is really consumed.
  localparam logic [TW_DEF-1:0] TUSE_BRANCH = 3'd0;  // beq/jr compare in D
  localparam logic [TW_DEF-1:0] TUSE_ALU    = 3'd1;  // ALU operands in E
  localparam logic [TW_DEF-1:0] TUSE_STORE  = 3'd2;  // sw data in M

  // Tnew: cycles after entering E until the result is forwardable.
  localparam logic [TW_DEF-1:0] TNEW_NONE   = 3'd0;
  localparam logic [TW_DEF-1:0] TNEW_ALU    = 3'd1;
  localparam logic [TW_DEF-1:0] TNEW_LOAD   = 3'd2;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Purpose : D-stage hazard bus between decode (master) and the
//           scoreboard (slave).
// Signals : d_valid/d_raddr/d_tuse/d_waddr/d_tnew/flush from decode;
//           stall/fwd_sel/stall_cnt back to decode and the pipeline.
interface hazard_scoreboard_if #(
  parameter int AW  = 5,
  parameter int TW  = 3,
  parameter int NRD = 2,
  parameter int SW  = 2,
  parameter int CW  = 32
);
  logic              d_valid;
  logic [NRD*AW-1:0] d_raddr;
  logic [NRD*TW-1:0] d_tuse;
  logic [AW-1:0]     d_waddr;
  logic [TW-1:0]     d_tnew;
  logic              flush;
  logic              stall;
  logic [NRD*SW-1:0] fwd_sel;
  logic [CW-1:0]     stall_cnt;

  modport master (
    output d_valid, d_raddr, d_tuse, d_waddr, d_tnew, flush,
    input  stall, fwd_sel, stall_cnt
  );

  modport slave (
    input  d_valid, d_raddr, d_tuse, d_waddr, d_tnew, flush,
    output stall, fwd_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// Purpose : youngest-match search for one read port over the tracked
//           pipeline entries.
// Ports   : i_waddr/i_tnew  flattened entries, index 0 = stage 1 (E)
//           i_raddr/i_tuse  the read port being checked
//           o_hit           some entry writes i_raddr
//           o_stage         stage number (1..NSTAGE) of the youngest hit
//           o_tnew          remaining Tnew of that entry
module hazard_scoreboard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int TW     = TW_DEF,
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int SW     = $clog2(NSTAGE_DEF + 1)
) (
  input  logic [NSTAGE*AW-1:0] i_waddr,
  input  logic [NSTAGE*TW-1:0] i_tnew,
  input  logic [AW-1:0]        i_raddr,
  input  logic [TW-1:0]        i_tuse,
  output logic                 o_hit,
  output logic [SW-1:0]        o_stage,
  output logic [TW-1:0]        o_tnew
);

  localparam logic [TW-1:0] TNONE = {TW{1'b1}};

  logic              w_en;
  logic [NSTAGE-1:0] w_m;

  // Per-entry match; $0 and unused operands never match.
  always_comb begin
    w_en = (i_raddr != '0) && (i_tuse != TNONE);
    w_m  = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      w_m[k] = w_en && (i_waddr[k*AW +: AW] == i_raddr);
    end
  end

  // Scan oldest to youngest so the youngest hit overwrites older ones.
  always_comb begin
    o_hit   = 1'b0;
    o_stage = '0;
    o_tnew  = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      o_hit   = w_m[k] ? 1'b1               : o_hit;
      o_stage = w_m[k] ? SW'(k + 1)         : o_stage;
      o_tnew  = w_m[k] ? i_tnew[k*TW +: TW] : o_tnew;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Purpose : Tuse/Tnew hazard unit beside the D stage. Tracks in-flight
//           writers through NSTAGE downstream stages, ageing Tnew each
//           cycle, and produces D-stage stall, forward selects and a
//           saturating stall counter.
// Ports   : clk, reset (async, active high)
//           hs  slave side of hazard_scoreboard_if (D inputs, flush,
//               stall, fwd_sel, stall_cnt)
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int TW     = TW_DEF,
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  hs
);

  localparam int            SW     = $clog2(NSTAGE + 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
    return (x == '0) ? '0 : x - {{(TW-1){1'b0}}, 1'b1};
  endfunction

  // Entry k-1 holds stage k; waddr 0 marks an empty slot / bubble.
  logic [AW-1:0]        r_waddr [NSTAGE];
  logic [TW-1:0]        r_tnew  [NSTAGE];
  logic [CW-1:0]        r_cnt;
  logic [NSTAGE*AW-1:0] w_waddr_flat;
  logic [NSTAGE*TW-1:0] w_tnew_flat;
  logic [NRD-1:0]       w_hit;
  logic [SW-1:0]        w_stage [NRD];
  logic [TW-1:0]        w_tnew_m [NRD];
  logic                 w_stall;
  logic [NRD*SW-1:0]    w_fwd;
  logic                 w_load;

  // Flatten entry state for the per-port search blocks.
  always_comb begin
    w_waddr_flat = '0;
    w_tnew_flat  = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      w_waddr_flat[k*AW +: AW] = r_waddr[k];
      w_tnew_flat[k*TW +: TW]  = r_tnew[k];
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_port
    hazard_scoreboard_match #(
      .AW(AW), .TW(TW), .NSTAGE(NSTAGE), .SW(SW)
    ) u_match (
      .i_waddr (w_waddr_flat),
      .i_tnew  (w_tnew_flat),
      .i_raddr (hs.d_raddr[gi*AW +: AW]),
      .i_tuse  (hs.d_tuse[gi*TW +: TW]),
      .o_hit   (w_hit[gi]),
      .o_stage (w_stage[gi]),
      .o_tnew  (w_tnew_m[gi])
    );
  end

  // Stall if any port's youngest producer is not ready by its Tuse;
  // forward from the stage only once its result is already available.
  always_comb begin
    w_stall = 1'b0;
    w_fwd   = '0;
    for (int i = 0; i < NRD; i++) begin
      if (w_hit[i] && (w_tnew_m[i] > hs.d_tuse[i*TW +: TW])) begin
        w_stall = 1'b1;
      end else begin
        w_stall = w_stall;
      end
      w_fwd[i*SW +: SW] = (w_hit[i] && (w_tnew_m[i] == '0)) ? w_stage[i] : '0;
    end
    w_load = hs.d_valid && !hs.flush && !w_stall;
  end

  // Entry shift register; downstream stages never stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NSTAGE; k++) begin
        r_waddr[k] <= '0;
        r_tnew[k]  <= '0;
      end
    end else begin
      r_waddr[0] <= w_load ? hs.d_waddr : '0;
      r_tnew[0]  <= w_load ? hs.d_tnew  : '0;
      for (int k = 1; k < NSTAGE; k++) begin
        r_waddr[k] <= r_waddr[k-1];
        r_tnew[k]  <= sat_dec(r_tnew[k-1]);
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign hs.stall     = w_stall;
  assign hs.fwd_sel   = w_fwd;
  assign hs.stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose : directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int AW = 5, TW = 3, NSTAGE = 3, NRD = 2, SW = 2, CW = 4;
  localparam logic [TW-1:0] TN = 3'b111;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  hazard_scoreboard_if #(.AW(AW), .TW(TW), .NRD(NRD), .SW(SW), .CW(CW)) hs ();

  hazard_scoreboard #(
    .AW(AW), .TW(TW), .NSTAGE(NSTAGE), .NRD(NRD), .CW(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hs    (hs)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] r0, input logic [TW-1:0] t0,
                       input logic [AW-1:0] r1, input logic [TW-1:0] t1,
                       input logic [AW-1:0] wa, input logic [TW-1:0] tn, input logic fl);
    hs.d_valid = v;
    hs.d_raddr = {r1, r0};
    hs.d_tuse  = {t1, t0};
    hs.d_waddr = wa;
    hs.d_tnew  = tn;
    hs.flush   = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 5'd0, TN, 5'd0, TN, 5'd0, 3'd0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] fwd0();
    logic [NRD*SW-1:0] f;
    f = hs.fwd_sel;
    return {30'd0, f[1:0]};
  endfunction

  function automatic logic [31:0] fwd1();
    logic [NRD*SW-1:0] f;
    f = hs.fwd_sel;
    return {30'd0, f[3:2]};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive(1'b0, 5'd0, TN, 5'd0, TN, 5'd0, 3'd0, 1'b0);
    #7;

    // 1: reset held, addu $3,$1,$2 at D
    drive(1'b1, 5'd1, TUSE_ALU, 5'd2, TUSE_ALU, 5'd3, TNEW_ALU, 1'b0);
    #1;
    chk("rst_stall", {31'd0, hs.stall}, 32'd0);
    chk("rst_fwd0", fwd0(), 32'd0);
    chk("rst_fwd1", fwd1(), 32'd0);
    chk("rst_cnt", {28'd0, hs.stall_cnt}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_stall", {31'd0, hs.stall}, 32'd0);
    chk("rel_fwd0", fwd0(), 32'd0);
    tick();

    // 2: lw $8 then addu $9,$8,$8 -> one stall
    do_reset();
    drive(1'b1, 5'd29, TUSE_ALU, 5'd0, TN, 5'd8, TNEW_LOAD, 1'b0);
    #1;
    chk("t2_lw_stall", {31'd0, hs.stall}, 32'd0);
    tick();
    drive(1'b1, 5'd8, TUSE_ALU, 5'd8, TUSE_ALU, 5'd9, TNEW_ALU, 1'b0);
    #1;
    chk("t2_stall", {31'd0, hs.stall}, 32'd1);
    tick();
    chk("t2_nostall", {31'd0, hs.stall}, 32'd0);
    chk("t2_cnt", {28'd0, hs.stall_cnt}, 32'd1);
    chk("t2_fwd0", fwd0(), 32'd0);
    tick();
    // lw now at stage 3 with tnew 0; stage 2 must be the bubble.
    drive(1'b1, 5'd8, TUSE_BRANCH, 5'd0, TN, 5'd0, TNEW_NONE, 1'b0);
    #1;
    chk("t2_bubble_fwd", fwd0(), 32'd3);
    chk("t2_bubble_stall", {31'd0, hs.stall}, 32'd0);

    // 3: lw $8 then jr $8 -> two stalls, then forward from stage 3
    do_reset();
    drive(1'b1, 5'd0, TN, 5'd0, TN, 5'd8, TNEW_LOAD, 1'b0);
    tick();
    drive(1'b1, 5'd8, TUSE_BRANCH, 5'd0, TN, 5'd0, TNEW_NONE, 1'b0);
    #1;
    chk("t3_stall_a", {31'd0, hs.stall}, 32'd1);
    tick();
    chk("t3_stall_b", {31'd0, hs.stall}, 32'd1);
    tick();
    chk("t3_stall_c", {31'd0, hs.stall}, 32'd0);
    chk("t3_fwd0", fwd0(), 32'd3);
    chk("t3_cnt", {28'd0, hs.stall_cnt}, 32'd2);

    // 4: addu $4 then sw rt=$4 -> no stall; next reader forwards from M
    do_reset();
    drive(1'b1, 5'd0, TN, 5'd0, TN, 5'd4, TNEW_ALU, 1'b0);
    tick();
    drive(1'b1, 5'd29, TUSE_ALU, 5'd4, TUSE_STORE, 5'd0, TNEW_NONE, 1'b0);
    #1;
    chk("t4_stall", {31'd0, hs.stall}, 32'd0);
    chk("t4_fwd1", fwd1(), 32'd0);
    tick();
    drive(1'b1, 5'd4, TUSE_ALU, 5'd0, TN, 5'd0, TNEW_NONE, 1'b0);
    #1;
    chk("t4_fwd0_m", fwd0(), 32'd2);
    chk("t4_stall2", {31'd0, hs.stall}, 32'd0);

    // 5: writes to $0 never create hazards
    do_reset();
    drive(1'b1, 5'd0, TN, 5'd0, TN, 5'd0, TNEW_LOAD, 1'b0);
    tick();
    drive(1'b1, 5'd0, TUSE_BRANCH, 5'd0, TUSE_BRANCH, 5'd0, TNEW_NONE, 1'b0);
    #1;
    chk("t5_stall", {31'd0, hs.stall}, 32'd0);
    chk("t5_fwd0", fwd0(), 32'd0);
    chk("t5_fwd1", fwd1(), 32'd0);

    // 6: youngest match wins over an older pending writer
    do_reset();
    drive(1'b1, 5'd0, TN, 5'd0, TN, 5'd8, TNEW_LOAD, 1'b0);
    tick();
    drive(1'b1, 5'd0, TN, 5'd0, TN, 5'd8, TNEW_NONE, 1'b0);
    tick();
    drive(1'b1, 5'd8, TUSE_BRANCH, 5'd0, TN, 5'd0, TNEW_NONE, 1'b0);
    #1;
    chk("t6_young_stall", {31'd0, hs.stall}, 32'd0);
    chk("t6_young_fwd", fwd0(), 32'd1);
    tick();
    // flush together with stall: one bubble, counter still counts
    drive(1'b1, 5'd0, TN, 5'd0, TN, 5'd9, TNEW_LOAD, 1'b0);
    tick();
    drive(1'b1, 5'd9, TUSE_BRANCH, 5'd0, TN, 5'd10, TNEW_ALU, 1'b1);
    #1;
    chk("t6_fl_stall", {31'd0, hs.stall}, 32'd1);
    tick();
    drive(1'b1, 5'd9, TUSE_BRANCH, 5'd0, TN, 5'd10, TNEW_ALU, 1'b0);
    #1;
    chk("t6_fl_cnt", {28'd0, hs.stall_cnt}, 32'd1);
    chk("t6_fl_stall2", {31'd0, hs.stall}, 32'd1);
    // reset mid-stall drops stall at once
    reset = 1'b1;
    #1;
    chk("t6_rst_stall", {31'd0, hs.stall}, 32'd0);
    chk("t6_rst_cnt", {28'd0, hs.stall_cnt}, 32'd0);
    tick();
    reset = 1'b0;

    // 7: counter saturates at 2^CW-1 (three stalls per round)
    for (int r = 0; r < 6; r++) begin
      drive(1'b1, 5'd0, TN, 5'd0, TN, 5'd9, 3'd7, 1'b0);
      tick();
      drive(1'b1, 5'd9, TUSE_BRANCH, 5'd0, TN, 5'd0, TNEW_NONE, 1'b0);
      for (int j = 0; j < 3; j++) begin
        #1;
        chk("t7_stall", {31'd0, hs.stall}, 32'd1);
        tick();
      end
      chk("t7_clear", {31'd0, hs.stall}, 32'd0);
      chk("t7_cnt", {28'd0, hs.stall_cnt}, (3 * (r + 1) > 15) ? 32'd15 : 32'(3 * (r + 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
